// File: rtl/spi_pkg.sv
// Shared definitions for the byte-wide SPI master: FSM encoding, SPI mode decode
// and the number of SCLK edges in one byte.
package spi_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } spi_state_t;

  localparam logic [4:0] EDGE_COUNT = 5'd16;

  function automatic logic mode_cpol(input int mode);
    return ((mode / 2) % 2) != 0;
  endfunction

  function automatic logic mode_cpha(input int mode);
    return (mode % 2) != 0;
  endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK generator: half-bit prescaler plus a down-counter of the 16 edges of a byte,
// with leading/trailing edge strobes for the data path.
module spi_edge_gen
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  output logic lead_edge,
  output logic trail_edge,
  output logic last_edge,
  output logic done,
  output logic spi_clk
);

  localparam int                HALF_W    = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic              CPOL      = mode_cpol(SPI_MODE);

  logic [HALF_W-1:0] half_cnt_r;
  logic [4:0]        edge_cnt_r;
  logic              sclk_r;
  logic              edge_s;

  // Edge strobes; an even remaining count means the next edge is a leading one
  always_comb begin
    edge_s     = 1'b0;
    lead_edge  = 1'b0;
    trail_edge = 1'b0;
    last_edge  = 1'b0;
    done       = 1'b0;
    if (active && (edge_cnt_r != 5'd0) && (half_cnt_r == HALF_LAST)) begin
      edge_s = 1'b1;
    end else begin
      edge_s = 1'b0;
    end
    lead_edge  = edge_s && !edge_cnt_r[0];
    trail_edge = edge_s && edge_cnt_r[0];
    last_edge  = edge_s && (edge_cnt_r == 5'd1);
    done       = active && (edge_cnt_r == 5'd0);
  end

  // Prescaler, edge counter and SCLK register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_cnt_r <= '0;
      edge_cnt_r <= 5'd0;
      sclk_r     <= CPOL;
    end else if (start) begin
      half_cnt_r <= '0;
      edge_cnt_r <= EDGE_COUNT;
      sclk_r     <= CPOL;
    end else if (edge_s) begin
      half_cnt_r <= '0;
      edge_cnt_r <= edge_cnt_r - 5'd1;
      sclk_r     <= ~sclk_r;
    end else if (active && (edge_cnt_r != 5'd0)) begin
      half_cnt_r <= half_cnt_r + HALF_W'(1);
    end else begin
      half_cnt_r <= '0;
    end
  end

  assign spi_clk = sclk_r;

endmodule

// File: rtl/spi_master_byte.sv
// Byte-wide SPI master: accepts one byte per i_TX_DV, shifts it out MSB-first and
// returns the byte captured from MISO with a one-cycle o_RX_DV.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);

  localparam logic CPHA = mode_cpha(SPI_MODE);

  spi_state_t state_r;
  logic [7:0] tx_sr_r;
  logic [7:0] rx_sr_r;
  logic       accept_s;
  logic       lead_s;
  logic       trail_s;
  logic       last_s;
  logic       done_s;
  logic       sample_s;
  logic       shift_s;

  spi_edge_gen #(
    .SPI_MODE         (SPI_MODE),
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_edge_gen (
    .clk       (clk),
    .rst_n     (i_Rst_L),
    .start     (accept_s),
    .active    (state_r == ST_XFER),
    .lead_edge (lead_s),
    .trail_edge(trail_s),
    .last_edge (last_s),
    .done      (done_s),
    .spi_clk   (o_SPI_Clk)
  );

  // Phase select: with CPHA=0 bit7 is already on MOSI, so the final trailing edge must not shift
  always_comb begin
    accept_s = 1'b0;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    if (CPHA) begin
      sample_s = trail_s;
      shift_s  = lead_s;
    end else begin
      sample_s = lead_s;
      shift_s  = trail_s && !last_s;
    end
    accept_s = (state_r == ST_IDLE) && i_TX_DV && o_TX_Ready;
  end

  // Transfer FSM with shift registers and handshake outputs
  always_ff @(posedge clk) begin
    if (!i_Rst_L) begin
      state_r    <= ST_IDLE;
      o_TX_Ready <= 1'b1;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= 8'h00;
      o_SPI_MOSI <= 1'b0;
      tx_sr_r    <= 8'h00;
      rx_sr_r    <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_RX_DV <= 1'b0;
          if (accept_s) begin
            state_r    <= ST_XFER;
            o_TX_Ready <= 1'b0;
            rx_sr_r    <= 8'h00;
            if (CPHA) begin
              tx_sr_r <= i_TX_Byte;
            end else begin
              o_SPI_MOSI <= i_TX_Byte[7];
              tx_sr_r    <= {i_TX_Byte[6:0], 1'b0};
            end
          end
        end
        ST_XFER: begin
          if (done_s) begin
            state_r    <= ST_IDLE;
            o_TX_Ready <= 1'b1;
            o_RX_DV    <= 1'b1;
            o_RX_Byte  <= rx_sr_r;
          end else begin
            if (shift_s) begin
              o_SPI_MOSI <= tx_sr_r[7];
              tx_sr_r    <= {tx_sr_r[6:0], 1'b0};
            end
            if (sample_s) begin
              rx_sr_r <= {rx_sr_r[6:0], i_SPI_MISO};
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          o_TX_Ready <= 1'b1;
          o_RX_DV    <= 1'b0;
        end
      endcase
    end
  end

endmodule
